// File: rtl/mnist_ds_pkg.sv
// rtl/mnist_ds_pkg.sv - shared state type, default geometry and width helpers for the MNIST downsampler
package mnist_ds_pkg;

   localparam int DS_DEF_IN_W     = 448;
   localparam int DS_DEF_IN_H     = 448;
   localparam int DS_DEF_LOG2_BLK = 4;
   localparam int DS_DEF_DATA_W   = 8;

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } ds_state_e;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int acc_width(input int data_w, input int log2_blk);
      return data_w + 2 * log2_blk;
   endfunction

endpackage

// File: rtl/mnist_tile_acc.sv
// rtl/mnist_tile_acc.sv - one accumulator per tile column with round-half-up average read-out
module mnist_tile_acc
   import mnist_ds_pkg::*;
#(
   parameter int OUT_W    = 28,
   parameter int LOG2_BLK = 4,
   parameter int DATA_W   = 8,
   parameter int ACC_W    = acc_width(DATA_W, LOG2_BLK),
   parameter int TX_W     = clog2_min1(OUT_W)
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              first_i,
   input  logic [TX_W-1:0]   tx_i,
   input  logic [DATA_W-1:0] pix_i,
   output logic [DATA_W-1:0] avg_o
);

   localparam int               HALF_SH = (LOG2_BLK > 0) ? 2 * LOG2_BLK - 1 : 0;
   localparam logic [ACC_W-1:0] HALF    = (LOG2_BLK > 0) ? (ACC_W'(1) << HALF_SH) : '0;

   logic [ACC_W-1:0] acc_q [OUT_W];
   logic [ACC_W-1:0] sum_d;
   logic [ACC_W-1:0] rounded;

   // The first pixel of a tile overwrites, so the bank never needs a reset.
   always_comb begin
      sum_d   = (first_i ? '0 : acc_q[tx_i]) + ACC_W'(pix_i);
      rounded = sum_d + HALF;
      avg_o   = rounded[2*LOG2_BLK +: DATA_W];
   end

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         acc_q[tx_i] <= sum_d;
      end
   end

endmodule

// File: rtl/mnist_block_downsample.sv
// rtl/mnist_block_downsample.sv - raster grey stream to tile-averaged MNIST image RAM writes
// Optional MNIST_DS_INVERT_EN: ds_data becomes (2^DATA_W-1) minus the rounded average.
module mnist_block_downsample
   import mnist_ds_pkg::*;
#(
   parameter  int IN_W     = DS_DEF_IN_W,
   parameter  int IN_H     = DS_DEF_IN_H,
   parameter  int LOG2_BLK = DS_DEF_LOG2_BLK,
   parameter  int DATA_W   = DS_DEF_DATA_W,
   localparam int OUT_W    = IN_W >> LOG2_BLK,
   localparam int OUT_H    = IN_H >> LOG2_BLK,
   localparam int ADDR_W   = clog2_min1(OUT_W * OUT_H)
) (
   input  logic              cmos_pclk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              pix_valid,
   input  logic [DATA_W-1:0] pix_data,
   output logic              ds_valid,
   output logic [DATA_W-1:0] ds_data,
   output logic [ADDR_W-1:0] ds_addr,
   output logic              frame_done,
   output logic              overrun
);

   localparam int ACC_W = acc_width(DATA_W, LOG2_BLK);
   localparam int H_W   = clog2_min1(IN_W);
   localparam int V_W   = clog2_min1(IN_H);
   localparam int TX_W  = clog2_min1(OUT_W);
   localparam int TY_W  = clog2_min1(OUT_H);
   localparam logic [LOG2_BLK-1:0] SUB_LAST = '1;

   ds_state_e         state_q, state_d;
   logic [H_W-1:0]    h_q, h_d, h_cur;
   logic [V_W-1:0]    v_q, v_d, v_cur;
   logic              overrun_q, overrun_d;
   logic              ds_valid_q, ds_valid_d;
   logic              frame_done_q, frame_done_d;
   logic [DATA_W-1:0] ds_data_q, ds_data_d;
   logic [ADDR_W-1:0] ds_addr_q, ds_addr_d;
   logic              take, tile_first, tile_last, h_last, frame_last;
   logic [TX_W-1:0]   tx;
   logic [TY_W-1:0]   ty;
   logic [DATA_W-1:0] avg;

   // frame_start makes the concurrent pixel (0,0) of the new frame.
   always_comb begin
      h_cur      = frame_start ? '0 : h_q;
      v_cur      = frame_start ? '0 : v_q;
      take       = pix_valid && (frame_start || state_q == RUN);
      tx         = TX_W'(h_cur >> LOG2_BLK);
      ty         = TY_W'(v_cur >> LOG2_BLK);
      h_last     = (h_cur == H_W'(IN_W - 1));
      frame_last = h_last && (v_cur == V_W'(IN_H - 1));
      tile_first = (h_cur[LOG2_BLK-1:0] == '0) && (v_cur[LOG2_BLK-1:0] == '0);
      tile_last  = take && (h_cur[LOG2_BLK-1:0] == SUB_LAST) &&
                   (v_cur[LOG2_BLK-1:0] == SUB_LAST);
   end

   mnist_tile_acc #(
      .OUT_W    (OUT_W),
      .LOG2_BLK (LOG2_BLK),
      .DATA_W   (DATA_W),
      .ACC_W    (ACC_W),
      .TX_W     (TX_W)
   ) u_tile_acc (
      .clk_i   (cmos_pclk),
      .en_i    (take),
      .first_i (tile_first),
      .tx_i    (tx),
      .pix_i   (pix_data),
      .avg_o   (avg)
   );

   always_comb begin
      state_d      = state_q;
      h_d          = h_cur;
      v_d          = v_cur;
      overrun_d    = overrun_q && !frame_start;
      ds_valid_d   = tile_last;
      frame_done_d = tile_last && frame_last;
      ds_data_d    = ds_data_q;
      ds_addr_d    = ds_addr_q;
      if (frame_start) begin
         state_d = RUN;
      end
      if (pix_valid && !take) begin
         overrun_d = 1'b1;
      end
      if (take) begin
         h_d = h_last ? '0 : h_cur + H_W'(1);
         if (h_last) begin
            v_d = frame_last ? '0 : v_cur + V_W'(1);
         end
         if (frame_last) begin
            state_d = DONE;
         end
      end
      if (tile_last) begin
         ds_data_d = avg;
         ds_addr_d = ADDR_W'(ty) * ADDR_W'(OUT_W) + ADDR_W'(tx);
      end
   end

   always_ff @(posedge cmos_pclk) begin
      if (rst) begin
         state_q      <= RUN;
         h_q          <= '0;
         v_q          <= '0;
         overrun_q    <= 1'b0;
         ds_valid_q   <= 1'b0;
         frame_done_q <= 1'b0;
         ds_data_q    <= '0;
         ds_addr_q    <= '0;
      end else begin
         state_q      <= state_d;
         h_q          <= h_d;
         v_q          <= v_d;
         overrun_q    <= overrun_d;
         ds_valid_q   <= ds_valid_d;
         frame_done_q <= frame_done_d;
         ds_data_q    <= ds_data_d;
         ds_addr_q    <= ds_addr_d;
      end
   end

   assign ds_valid   = ds_valid_q;
   assign ds_addr    = ds_addr_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;
`ifdef MNIST_DS_INVERT_EN
   assign ds_data    = ~ds_data_q;
`else
   assign ds_data    = ds_data_q;
`endif

endmodule

// File: tb/tb_mnist_block_downsample.sv
// tb/tb_mnist_block_downsample.sv - randomized self-checking bench against a tile-sum reference model
`timescale 1ns/1ps
module tb_mnist_block_downsample;

   localparam int IN_W     = 32;
   localparam int IN_H     = 16;
   localparam int LOG2_BLK = 2;
   localparam int DATA_W   = 8;
   localparam int BLK      = 1 << LOG2_BLK;
   localparam int OUT_W    = IN_W / BLK;
   localparam int OUT_H    = IN_H / BLK;
   localparam int ADDR_W   = $clog2(OUT_W * OUT_H);
`ifdef MNIST_DS_INVERT_EN
   localparam logic [DATA_W-1:0] RST_DATA  = 8'hFF;
   localparam logic [DATA_W-1:0] SPLIT_EXP = 8'd127;
   localparam logic [DATA_W-1:0] RAMP_EXP  = 8'd241;
`else
   localparam logic [DATA_W-1:0] RST_DATA  = 8'h00;
   localparam logic [DATA_W-1:0] SPLIT_EXP = 8'd128;
   localparam logic [DATA_W-1:0] RAMP_EXP  = 8'd14;
`endif

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
      logic              done;
   } ds_ev_t;

   logic              cmos_pclk = 1'b0;
   logic              rst = 1'b1;
   logic              frame_start = 1'b0;
   logic              pix_valid = 1'b0;
   logic [DATA_W-1:0] pix_data = '0;
   logic              ds_valid;
   logic [DATA_W-1:0] ds_data;
   logic [ADDR_W-1:0] ds_addr;
   logic              frame_done;
   logic              overrun;

   int     checks = 0;
   int     failures = 0;
   int     stray_done = 0;
   int     img [IN_H][IN_W];
   ds_ev_t obs_q[$];
   ds_ev_t exp_q[$];
   ds_ev_t mon_ev;

   always #5 cmos_pclk = ~cmos_pclk;

   mnist_block_downsample #(
      .IN_W     (IN_W),
      .IN_H     (IN_H),
      .LOG2_BLK (LOG2_BLK),
      .DATA_W   (DATA_W)
   ) dut (
      .cmos_pclk   (cmos_pclk),
      .rst         (rst),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .ds_valid    (ds_valid),
      .ds_data     (ds_data),
      .ds_addr     (ds_addr),
      .frame_done  (frame_done),
      .overrun     (overrun)
   );

   always @(negedge cmos_pclk) begin
      if (ds_valid === 1'b1) begin
         mon_ev.data = ds_data;
         mon_ev.addr = ds_addr;
         mon_ev.done = frame_done;
         obs_q.push_back(mon_ev);
      end else if (frame_done === 1'b1) begin
         stray_done++;
      end
   end

   function automatic logic [DATA_W-1:0] exp_pix(input int sum);
      int avg;
      avg = (sum + (BLK * BLK) / 2) / (BLK * BLK);
`ifdef MNIST_DS_INVERT_EN
      return DATA_W'((1 << DATA_W) - 1 - avg);
`else
      return DATA_W'(avg);
`endif
   endfunction

   // Every tile whose rows all arrive yields one output, raster order by tile.
   task automatic build_expected(input int lines);
      ds_ev_t e;
      for (int ty = 0; ty < OUT_H; ty++) begin
         if ((ty + 1) * BLK <= lines) begin
            for (int tx = 0; tx < OUT_W; tx++) begin
               int sum = 0;
               for (int y = 0; y < BLK; y++)
                  for (int x = 0; x < BLK; x++)
                     sum += img[ty*BLK + y][tx*BLK + x];
               e.data = exp_pix(sum);
               e.addr = ADDR_W'(ty * OUT_W + tx);
               e.done = (ty == OUT_H - 1) && (tx == OUT_W - 1);
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic fill_img(input int mode, input int val);
      for (int v = 0; v < IN_H; v++)
         for (int h = 0; h < IN_W; h++)
            case (mode)
               0:       img[v][h] = val;
               1:       img[v][h] = int'($urandom_range(255, 0));
               2:       img[v][h] = (v < BLK && h < BLK / 2) ? 255 : 0;
               default: img[v][h] = h + 8 * v;
            endcase
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge cmos_pclk);
         pix_valid   = 1'b0;
         frame_start = 1'b0;
      end
   endtask

   task automatic drive_frame(input int lines, input bit fs_first, input int gap_min, input int gap_max);
      for (int v = 0; v < lines; v++) begin
         for (int h = 0; h < IN_W; h++) begin
            int gap = int'($urandom_range(gap_max, gap_min));
            for (int g = 0; g < gap; g++) begin
               @(negedge cmos_pclk);
               pix_valid   = 1'b0;
               frame_start = 1'b0;
            end
            @(negedge cmos_pclk);
            pix_valid   = 1'b1;
            pix_data    = DATA_W'(img[v][h]);
            frame_start = fs_first && (v == 0) && (h == 0);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      checks += 5;
      if (ds_valid !== 1'b0) begin failures++; $display("FAIL reset_ds_valid: got %b want 0", ds_valid); end
      if (ds_data !== RST_DATA) begin failures++; $display("FAIL reset_ds_data: got %0d want %0d", ds_data, RST_DATA); end
      if (ds_addr !== '0) begin failures++; $display("FAIL reset_ds_addr: got %0d want 0", ds_addr); end
      if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      @(negedge cmos_pclk);
      rst = 1'b0;
   endtask

   task automatic test_uniform();
      obs_q.delete(); exp_q.delete();
      fill_img(0, 200);
      build_expected(IN_H);
      drive_frame(IN_H, 1'b0, 1, 1);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL uniform_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL uniform_out[%0d]: got d=%0d a=%0d fd=%b want d=%0d a=%0d fd=%b", i, obs_q[i].data, obs_q[i].addr, obs_q[i].done, exp_q[i].data, exp_q[i].addr, exp_q[i].done); end
      end
      checks++;
      if (overrun !== 1'b0) begin failures++; $display("FAIL uniform_overrun: got %b want 0", overrun); end
   endtask

   task automatic test_split_tile();
      obs_q.delete(); exp_q.delete();
      fill_img(2, 0);
      build_expected(IN_H);
      drive_frame(IN_H, 1'b1, 0, 3);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL split_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL split_out[%0d]: got d=%0d a=%0d fd=%b want d=%0d a=%0d fd=%b", i, obs_q[i].data, obs_q[i].addr, obs_q[i].done, exp_q[i].data, exp_q[i].addr, exp_q[i].done); end
      end
      checks++;
      if (obs_q.size() == 0 || obs_q[0].data !== SPLIT_EXP) begin failures++; $display("FAIL split_tile0: got %0d (outputs %0d) want %0d", (obs_q.size() > 0) ? obs_q[0].data : '0, obs_q.size(), SPLIT_EXP); end
   endtask

   task automatic test_overrun();
      obs_q.delete(); exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         @(negedge cmos_pclk);
         pix_valid = 1'b1;
         pix_data  = DATA_W'($urandom_range(255, 0));
      end
      idle(3);
      checks += 2;
      if (obs_q.size() != 0) begin failures++; $display("FAIL overrun_no_output: got %0d outputs want 0", obs_q.size()); end
      if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b want 1", overrun); end
      @(negedge cmos_pclk);
      frame_start = 1'b1;
      idle(1);
      checks++;
      if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear: got %b want 0", overrun); end
      fill_img(1, 0);
      build_expected(IN_H);
      drive_frame(IN_H, 1'b0, 0, 2);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL overrun_frame_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL overrun_frame_out[%0d]: got d=%0d a=%0d fd=%b want d=%0d a=%0d fd=%b", i, obs_q[i].data, obs_q[i].addr, obs_q[i].done, exp_q[i].data, exp_q[i].addr, exp_q[i].done); end
      end
      checks++;
      if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_after_frame: got %b want 0", overrun); end
   endtask

   task automatic test_resync();
      fill_img(1, 0);
      drive_frame(6, 1'b1, 0, 2);
      idle(2);
      obs_q.delete(); exp_q.delete();
      fill_img(0, 50);
      build_expected(IN_H);
      drive_frame(IN_H, 1'b1, 0, 2);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL resync_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL resync_out[%0d]: got d=%0d a=%0d fd=%b want d=%0d a=%0d fd=%b", i, obs_q[i].data, obs_q[i].addr, obs_q[i].done, exp_q[i].data, exp_q[i].addr, exp_q[i].done); end
      end
   endtask

   task automatic test_back_to_back();
      obs_q.delete(); exp_q.delete();
      fill_img(1, 0);
      build_expected(IN_H);
      drive_frame(IN_H, 1'b1, 0, 0);
      fill_img(1, 0);
      build_expected(IN_H);
      drive_frame(IN_H, 1'b1, 0, 0);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_out[%0d]: got d=%0d a=%0d fd=%b want d=%0d a=%0d fd=%b", i, obs_q[i].data, obs_q[i].addr, obs_q[i].done, exp_q[i].data, exp_q[i].addr, exp_q[i].done); end
      end
   endtask

   task automatic test_reset_mid();
      fill_img(1, 0);
      drive_frame(7, 1'b1, 0, 1);
      @(negedge cmos_pclk);
      rst       = 1'b1;
      pix_valid = 1'b1;
      @(negedge cmos_pclk);
      checks += 4;
      if (ds_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ds_valid: got %b want 0", ds_valid); end
      if (ds_data !== RST_DATA) begin failures++; $display("FAIL rstmid_ds_data: got %0d want %0d", ds_data, RST_DATA); end
      if (ds_addr !== '0) begin failures++; $display("FAIL rstmid_ds_addr: got %0d want 0", ds_addr); end
      if (frame_done !== 1'b0) begin failures++; $display("FAIL rstmid_frame_done: got %b want 0", frame_done); end
      rst       = 1'b0;
      pix_valid = 1'b0;
      obs_q.delete(); exp_q.delete();
      fill_img(1, 0);
      build_expected(IN_H);
      drive_frame(IN_H, 1'b0, 0, 2);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rstmid_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_out[%0d]: got d=%0d a=%0d fd=%b want d=%0d a=%0d fd=%b", i, obs_q[i].data, obs_q[i].addr, obs_q[i].done, exp_q[i].data, exp_q[i].addr, exp_q[i].done); end
      end
   endtask

   task automatic test_ramp();
      obs_q.delete(); exp_q.delete();
      fill_img(3, 0);
      build_expected(IN_H);
      drive_frame(IN_H, 1'b1, 0, 1);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL ramp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL ramp_out[%0d]: got d=%0d a=%0d fd=%b want d=%0d a=%0d fd=%b", i, obs_q[i].data, obs_q[i].addr, obs_q[i].done, exp_q[i].data, exp_q[i].addr, exp_q[i].done); end
      end
      checks++;
      if (obs_q.size() == 0 || obs_q[0].data !== RAMP_EXP) begin failures++; $display("FAIL ramp_tile0: got %0d (outputs %0d) want %0d", (obs_q.size() > 0) ? obs_q[0].data : '0, obs_q.size(), RAMP_EXP); end
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_split_tile();
      test_overrun();
      test_resync();
      test_back_to_back();
      test_reset_mid();
      test_ramp();
      checks++;
      if (stray_done != 0) begin failures++; $display("FAIL stray_frame_done: got %0d pulses without ds_valid want 0", stray_done); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
